// File: rtl/bht_bimodal_sweep_if.sv
// Frontend <-> BHT bundle: lookup PC, resolved-branch update, flush/debug
// controls, and the per-slot prediction and sweep status returned by the table.
interface bht_bimodal_sweep_if #(
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter int unsigned VLEN            = 64
);
  logic                       flush_bht_i;
  logic                       debug_mode_i;
  logic [VLEN-1:0]            vpc_i;
  logic                       bht_update_valid_i;
  logic [VLEN-1:0]            bht_update_pc_i;
  logic                       bht_update_taken_i;
  logic [INSTR_PER_FETCH-1:0] bht_valid_o;
  logic [INSTR_PER_FETCH-1:0] bht_taken_o;
  logic                       busy_o;

  // Frontend side: issues lookups/updates, consumes predictions.
  modport master (
    output flush_bht_i, debug_mode_i, vpc_i,
           bht_update_valid_i, bht_update_pc_i, bht_update_taken_i,
    input  bht_valid_o, bht_taken_o, busy_o
  );

  // Table side.
  modport slave (
    input  flush_bht_i, debug_mode_i, vpc_i,
           bht_update_valid_i, bht_update_pc_i, bht_update_taken_i,
    output bht_valid_o, bht_taken_o, busy_o
  );
endinterface

// File: rtl/bht_bimodal_sweep.sv
// Bimodal branch history table: rows of 2-bit saturating counters, one row
// written per cycle. A sweep FSM clears the table one row per cycle after
// reset or flush; updates run through a two-stage read-modify-write pipe.
module bht_bimodal_sweep #(
  parameter int unsigned BHT_ENTRIES     = 512,
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter int unsigned VLEN            = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  bht_bimodal_sweep_if.slave bht
);

  localparam int unsigned NR_ROWS  = BHT_ENTRIES / INSTR_PER_FETCH;
  localparam int unsigned ROW_BITS = $clog2(NR_ROWS);
  localparam int unsigned COL_BITS = $clog2(INSTR_PER_FETCH);
  localparam int unsigned OFFSET   = 1;

  typedef struct packed {
    logic       valid;
    logic [1:0] cnt;
  } entry_t;

  typedef entry_t [INSTR_PER_FETCH-1:0] row_t;

  typedef enum logic {
    SWEEP,
    RUN
  } state_t;

  row_t                mem [NR_ROWS];

  state_t              state;
  logic [ROW_BITS-1:0] sweep_idx;

  // Stage-1 pipeline register of an accepted update.
  logic                upd_valid;
  logic [ROW_BITS-1:0] upd_row;
  logic [COL_BITS-1:0] upd_col;
  logic                upd_taken;

  logic                accept;
  logic [ROW_BITS-1:0] in_row;
  logic [COL_BITS-1:0] in_col;
  logic [ROW_BITS-1:0] lk_row_idx;

  row_t                cur_row;
  entry_t              cur_entry;
  entry_t              new_entry;
  row_t                new_row;
  row_t                lk_row;

  logic                wr_en;
  logic [ROW_BITS-1:0] wr_row;
  row_t                wr_data;

  assign in_row     = bht.bht_update_pc_i[OFFSET+COL_BITS +: ROW_BITS];
  assign in_col     = bht.bht_update_pc_i[OFFSET +: COL_BITS];
  assign lk_row_idx = bht.vpc_i[OFFSET+COL_BITS +: ROW_BITS];

  assign accept = bht.bht_update_valid_i & ~bht.debug_mode_i &
                  (state == RUN) & ~bht.flush_bht_i;

  assign bht.busy_o = (state == SWEEP);

  // Sweep FSM and stage-1 capture of resolved-branch updates.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= SWEEP;
      sweep_idx <= '0;
      upd_valid <= 1'b0;
      upd_row   <= '0;
      upd_col   <= '0;
      upd_taken <= 1'b0;
    end else begin
      upd_valid <= accept;
      upd_row   <= in_row;
      upd_col   <= in_col;
      upd_taken <= bht.bht_update_taken_i;
      case (state)
        SWEEP: begin
          if (bht.flush_bht_i) begin
            sweep_idx <= '0;
          end else if (sweep_idx == ROW_BITS'(NR_ROWS - 1)) begin
            state     <= RUN;
            sweep_idx <= '0;
          end else begin
            sweep_idx <= sweep_idx + 1'b1;
          end
        end
        RUN: begin
          if (bht.flush_bht_i) begin
            state     <= SWEEP;
            sweep_idx <= '0;
          end
        end
        default: begin
          state     <= SWEEP;
          sweep_idx <= '0;
        end
      endcase
    end
  end

  // Stage 2: read-modify-write of the addressed entry. The array read is
  // asynchronous, so a row written last cycle is already seen here; this
  // acts as the forward path for back-to-back updates to the same row.
  always_comb begin
    cur_row   = mem[upd_row];
    cur_entry = cur_row[upd_col];
    new_entry = cur_entry;
    if (!cur_entry.valid) begin
      new_entry.valid = 1'b1;
      new_entry.cnt   = upd_taken ? 2'b10 : 2'b01;
    end else if (upd_taken) begin
      if (cur_entry.cnt != 2'b11) new_entry.cnt = cur_entry.cnt + 2'b01;
    end else begin
      if (cur_entry.cnt != 2'b00) new_entry.cnt = cur_entry.cnt - 2'b01;
    end
    new_row          = cur_row;
    new_row[upd_col] = new_entry;
  end

  // Single write port: sweep clears have priority; a flush abandons stage 2.
  always_comb begin
    wr_en   = 1'b0;
    wr_row  = '0;
    wr_data = '0;
    if (state == SWEEP) begin
      wr_en   = 1'b1;
      wr_row  = sweep_idx;
      wr_data = '0;
    end else if (upd_valid && !bht.flush_bht_i) begin
      wr_en   = 1'b1;
      wr_row  = upd_row;
      wr_data = new_row;
    end
  end

  // Counter storage; no reset, contents are trusted only after a sweep.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_row] <= wr_data;
  end

  // Combinational lookup, forced to zero while sweeping.
  always_comb begin
    lk_row          = mem[lk_row_idx];
    bht.bht_valid_o = '0;
    bht.bht_taken_o = '0;
    for (int unsigned i = 0; i < INSTR_PER_FETCH; i++) begin
      bht.bht_valid_o[i] = (state == RUN) & lk_row[i].valid;
      bht.bht_taken_o[i] = (state == RUN) & lk_row[i].valid & lk_row[i].cnt[1];
    end
  end

endmodule

// File: tb/tb_bht_bimodal_sweep.sv
// Directed bench for bht_bimodal_sweep with hand-computed expectations.
module tb_bht_bimodal_sweep;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  bht_bimodal_sweep_if #(.INSTR_PER_FETCH(2), .VLEN(64)) bus ();

  bht_bimodal_sweep #(
    .BHT_ENTRIES    (512),
    .INSTR_PER_FETCH(2),
    .VLEN           (64)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bht   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One update, then one more cycle so the stage-2 write has landed.
  task automatic upd(input logic [63:0] pc, input logic taken);
    bus.bht_update_valid_i = 1'b1;
    bus.bht_update_pc_i    = pc;
    bus.bht_update_taken_i = taken;
    tick();
    bus.bht_update_valid_i = 1'b0;
    tick();
  endtask

  task automatic look(input string tag, input logic [63:0] pc,
                      input logic [1:0] exp_v, input logic [1:0] exp_t);
    bus.vpc_i = pc;
    #1;
    check({tag, "_valid"}, 64'(bus.bht_valid_o), 64'(exp_v));
    check({tag, "_taken"}, 64'(bus.bht_taken_o), 64'(exp_t));
  endtask

  // Counts samples with busy high; optionally pokes an update near the end.
  task automatic sweep_len(output int n, input bit inject);
    n = 0;
    while (bus.busy_o && n < 2000) begin
      n++;
      if (inject && n == 10) begin
        bus.vpc_i = 64'h8000_0004;
        #1;
        check("sweep_lookup_valid", 64'(bus.bht_valid_o), 64'h0);
      end
      if (inject && n == 250) begin
        bus.bht_update_valid_i = 1'b1;
        bus.bht_update_pc_i    = 64'h300;
        bus.bht_update_taken_i = 1'b1;
      end
      if (inject && n == 251) bus.bht_update_valid_i = 1'b0;
      tick();
    end
    bus.bht_update_valid_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [1:0] sat_taken [7];
  logic [1:0] sat_exp   [7];
  int n;

  initial begin
    errors = 0;
    checks = 0;
    sat_taken = '{1, 1, 1, 1, 0, 0, 0};
    sat_exp   = '{1, 1, 1, 1, 1, 0, 0};

    rst                    = 1'b1;
    bus.flush_bht_i        = 1'b0;
    bus.debug_mode_i       = 1'b0;
    bus.vpc_i              = '0;
    bus.bht_update_valid_i = 1'b0;
    bus.bht_update_pc_i    = '0;
    bus.bht_update_taken_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(bus.busy_o), 64'h1);
    check("reset_valid", 64'(bus.bht_valid_o), 64'h0);
    check("reset_taken", 64'(bus.bht_taken_o), 64'h0);
    rst = 1'b0;

    sweep_len(n, 1'b0);
    check("sweep_len", 64'(n), 64'd256);
    check("sweep_done_busy", 64'(bus.busy_o), 64'h0);
    look("post_sweep_0", 64'h0, 2'b00, 2'b00);
    look("post_sweep_1", 64'h8000_0004, 2'b00, 2'b00);

    // First update: not visible at N+1, visible at N+2.
    bus.bht_update_valid_i = 1'b1;
    bus.bht_update_pc_i    = 64'h8000_0004;
    bus.bht_update_taken_i = 1'b1;
    tick();
    bus.bht_update_valid_i = 1'b0;
    look("first_n1", 64'h8000_0004, 2'b00, 2'b00);
    tick();
    look("first_n2", 64'h8000_0004, 2'b01, 2'b01);
    look("first_other_row", 64'h8000_0008, 2'b00, 2'b00);

    // Saturation path on pc 0x100: cnt 10,11,11,11,10,01,00.
    for (int i = 0; i < 7; i++) begin
      upd(64'h100, sat_taken[i][0]);
      look($sformatf("sat_%0d", i), 64'h100, 2'b01, sat_exp[i]);
    end

    // Three taken updates back to back: cnt must reach 11.
    bus.bht_update_valid_i = 1'b1;
    bus.bht_update_pc_i    = 64'h200;
    bus.bht_update_taken_i = 1'b1;
    repeat (3) tick();
    bus.bht_update_valid_i = 1'b0;
    tick();
    look("b2b", 64'h200, 2'b01, 2'b01);
    upd(64'h200, 1'b0);
    look("b2b_was_11", 64'h200, 2'b01, 2'b01);

    // Same row, different columns back to back: both become cnt 10.
    bus.bht_update_valid_i = 1'b1;
    bus.bht_update_pc_i    = 64'h208;
    bus.bht_update_taken_i = 1'b1;
    tick();
    bus.bht_update_pc_i    = 64'h20A;
    tick();
    bus.bht_update_valid_i = 1'b0;
    tick();
    look("row_cols", 64'h208, 2'b11, 2'b11);
    upd(64'h208, 1'b0);
    upd(64'h20A, 1'b0);
    look("row_cols_were_10", 64'h20A, 2'b11, 2'b00);

    // Debug mode drops updates.
    bus.debug_mode_i = 1'b1;
    upd(64'h400, 1'b1);
    upd(64'h400, 1'b1);
    bus.debug_mode_i = 1'b0;
    look("debug", 64'h400, 2'b00, 2'b00);

    // Flush while an update sits in stage 2.
    bus.bht_update_valid_i = 1'b1;
    bus.bht_update_pc_i    = 64'h600;
    bus.bht_update_taken_i = 1'b1;
    tick();
    bus.bht_update_valid_i = 1'b0;
    bus.flush_bht_i        = 1'b1;
    tick();
    bus.flush_bht_i        = 1'b0;
    check("flush_busy", 64'(bus.busy_o), 64'h1);
    sweep_len(n, 1'b1);
    check("flush_sweep_len", 64'(n), 64'd256);
    tick();
    look("flush_lost", 64'h600, 2'b00, 2'b00);
    look("flush_cleared", 64'h8000_0004, 2'b00, 2'b00);
    look("flush_row_cols", 64'h208, 2'b00, 2'b00);
    look("sweep_upd_ignored", 64'h300, 2'b00, 2'b00);

    // Asynchronous reset in RUN clears outputs without a clock edge.
    upd(64'h100, 1'b1);
    look("pre_rst", 64'h100, 2'b01, 2'b01);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(bus.bht_valid_o), 64'h0);
    check("async_rst_busy", 64'(bus.busy_o), 64'h1);
    tick();
    rst = 1'b0;

    // Reset at sweep_idx 100 restarts the full sweep.
    repeat (100) tick();
    check("mid_sweep_busy", 64'(bus.busy_o), 64'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sweep_len(n, 1'b0);
    check("restart_sweep_len", 64'(n), 64'd256);
    look("restart_cleared", 64'h100, 2'b00, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
